// File: rtl/instmem_loader.sv
// Instruction memory with combinational fetch port plus a byte-stream program loader.
// Fetch: zero latency. Loader: one byte per cycle while ld_ready; CPU held in reset until load completes.
module instmem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_progcntr,
    input  logic              i_fetch,
    output logic [15:0]       o_inst,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_byte,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_cpu_hold,
    output logic [ADDR_W:0]   o_words_loaded,
    output logic              o_err_ovf,
    output logic              o_err_oob
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_hi;
    logic [ADDR_W:0]  r_ptr;
    logic             r_cpu_hold;
    logic             r_err_ovf;
    logic             r_err_oob;
    logic [15:0]      r_mem [0:(1<<ADDR_W)-1];

    logic             w_ld_ready;
    logic             w_hs_hi;
    logic             w_hs_lo;
    logic             w_full;
    logic             w_wr;
    logic             w_oob_addr;
    logic             w_run_fetch;

    // ld_start outranks any byte presented in the same cycle
    assign w_hs_hi     = (r_state == S_LOAD_HI) && i_ld_valid && w_ld_ready && !i_ld_start;
    assign w_hs_lo     = (r_state == S_LOAD_LO) && i_ld_valid && w_ld_ready && !i_ld_start;
    assign w_full      = r_ptr[ADDR_W];
    assign w_wr        = w_hs_lo && !w_full && !i_rst;
    assign w_oob_addr  = |i_progcntr[15:ADDR_W];
    assign w_run_fetch = (r_state == S_RUN) && i_fetch;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = S_IDLE;
            S_LOAD_HI: if (i_ld_valid) w_next = S_LOAD_LO;
            S_LOAD_LO: if (i_ld_valid) w_next = i_ld_last ? S_RELEASE : S_LOAD_HI;
            S_RELEASE: w_next = S_RUN;
            S_RUN:     w_next = S_RUN;
            default:   w_next = S_IDLE;
        endcase
        if (i_ld_start) begin
            w_next = S_LOAD_HI;
        end
    end

    always_comb begin
        w_ld_ready = 1'b0;
        case (r_state)
            S_LOAD_HI, S_LOAD_LO: w_ld_ready = 1'b1;
            default:              w_ld_ready = 1'b0;
        endcase
    end

    // Loader datapath; cpu_hold is registered off the next state so it drops cleanly entering RUN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi       <= 8'h00;
            r_ptr      <= '0;
            r_cpu_hold <= 1'b1;
            r_err_ovf  <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            r_cpu_hold <= (w_next != S_RUN);
            if (i_ld_start) begin
                r_hi      <= 8'h00;
                r_ptr     <= '0;
                r_err_ovf <= 1'b0;
                r_err_oob <= 1'b0;
            end else begin
                if (w_hs_hi) begin
                    r_hi <= i_ld_byte;
                end
                if (w_hs_lo) begin
                    if (w_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                if (w_run_fetch && w_oob_addr) begin
                    r_err_oob <= 1'b1;
                end
            end
        end
    end

    // Array is deliberately outside reset so a reset never destroys a loaded program
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_ptr[ADDR_W-1:0]] <= {r_hi, i_ld_byte};
        end
    end

    always_comb begin
        o_inst = 16'h0000;
        if (w_run_fetch && !w_oob_addr) begin
            o_inst = r_mem[i_progcntr[ADDR_W-1:0]];
        end
    end

    assign o_ld_ready     = w_ld_ready;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_words_loaded = r_ptr;
    assign o_err_ovf      = r_err_ovf;
    assign o_err_oob      = r_err_oob;

endmodule

// File: tb/tb_instmem_loader.sv
// Bench for instmem_loader: a 256-word and a 4-word instance share stimulus; expected
// memory contents and status come from the list of words each load delivered.
module tb_instmem_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fetch, ld_start, ld_valid, ld_last;
    logic [15:0] pc;
    logic [7:0]  ld_byte;

    logic [15:0] inst_a, inst_b;
    logic        rdy_a, rdy_b, hold_a, hold_b, ovf_a, ovf_b, oob_a, oob_b;
    logic [8:0]  wl_a;
    logic [2:0]  wl_b;

    instmem_loader #(.ADDR_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_progcntr(pc), .i_fetch(fetch), .o_inst(inst_a),
        .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_byte(ld_byte), .i_ld_last(ld_last),
        .o_ld_ready(rdy_a), .o_cpu_hold(hold_a), .o_words_loaded(wl_a),
        .o_err_ovf(ovf_a), .o_err_oob(oob_a));

    instmem_loader #(.ADDR_W(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_progcntr(pc), .i_fetch(fetch), .o_inst(inst_b),
        .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_byte(ld_byte), .i_ld_last(ld_last),
        .o_ld_ready(rdy_b), .o_cpu_hold(hold_b), .o_words_loaded(wl_b),
        .o_err_ovf(ovf_b), .o_err_oob(oob_b));

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_a [256];
    bit          kn_a  [256];
    logic [15:0] ref_b [4];
    bit          kn_b  [4];
    logic [15:0] cur [$];

    // Reference: word i of a load lands at address i if it fits, otherwise it is dropped
    task automatic apply_model();
        foreach (cur[i]) begin
            if (i < 256) begin ref_a[i] = cur[i]; kn_a[i] = 1'b1; end
            if (i < 4)   begin ref_b[i] = cur[i]; kn_b[i] = 1'b1; end
        end
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        cur.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int gap;
        gap = $urandom_range(0, 3);
        ld_valid = 1'b0;
        repeat (gap) begin
            ld_byte = 8'($urandom);
            ld_last = 1'($urandom);
            @(negedge clk);
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        checks++;
        if ({rdy_a, rdy_b, hold_a, hold_b} !== 4'b1111) begin
            errors++;
            $display("FAIL load_ready_hold: ready=%b/%b hold=%b/%b, required all 1", rdy_a, rdy_b, hold_a, hold_b);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic last);
        send_byte(w[15:8], 1'($urandom));
        send_byte(w[7:0], last);
        cur.push_back(w);
    endtask

    task automatic check_status(input string name);
        int n, ea, eb;
        n  = cur.size();
        ea = (n > 256) ? 256 : n;
        eb = (n > 4) ? 4 : n;
        checks++;
        if (wl_a !== ea[8:0] || wl_b !== eb[2:0]) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d/%0d, required %0d/%0d", name, wl_a, wl_b, ea, eb);
        end
        checks++;
        if (ovf_a !== (n > 256) || ovf_b !== (n > 4)) begin
            errors++;
            $display("FAIL %s err_ovf: got %b/%b, required %b/%b", name, ovf_a, ovf_b, n > 256, n > 4);
        end
    endtask

    // Called right after the handshake of the last byte
    task automatic finish_load(input string name);
        checks++;
        if ({hold_a, hold_b, rdy_a, rdy_b} !== 4'b1100) begin
            errors++;
            $display("FAIL %s release: hold=%b/%b ready=%b/%b, required hold 1 ready 0", name, hold_a, hold_b, rdy_a, rdy_b);
        end
        @(negedge clk);
        checks++;
        if ({hold_a, hold_b} !== 2'b00) begin
            errors++;
            $display("FAIL %s run_hold: hold=%b/%b, required 0", name, hold_a, hold_b);
        end
        apply_model();
        check_status(name);
    endtask

    task automatic check_fetch(input string name, input logic [15:0] addr);
        fetch = 1'b1;
        pc    = addr;
        #1;
        if (addr >= 16'd256 || kn_a[addr[7:0]]) begin
            checks++;
            if (inst_a !== ((addr >= 16'd256) ? 16'h0000 : ref_a[addr[7:0]])) begin
                errors++;
                $display("FAIL %s inst_a pc=%h: got %h, required %h", name, addr, inst_a,
                         (addr >= 16'd256) ? 16'h0000 : ref_a[addr[7:0]]);
            end
        end
        if (addr >= 16'd4 || kn_b[addr[1:0]]) begin
            checks++;
            if (inst_b !== ((addr >= 16'd4) ? 16'h0000 : ref_b[addr[1:0]])) begin
                errors++;
                $display("FAIL %s inst_b pc=%h: got %h, required %h", name, addr, inst_b,
                         (addr >= 16'd4) ? 16'h0000 : ref_b[addr[1:0]]);
            end
        end
        @(negedge clk);
        fetch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch = 1'b0; pc = 16'h0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_last = 1'b0; ld_byte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fetch = 1'b1;
        ld_valid = 1'b1;
        #1;
        checks++;
        if ({rdy_a, rdy_b, hold_a, hold_b, ovf_a, ovf_b, oob_a, oob_b} !== 8'b0011_0000
            || wl_a !== 9'd0 || wl_b !== 3'd0 || inst_a !== 16'h0 || inst_b !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b/%b hold=%b/%b ovf=%b/%b oob=%b/%b wl=%0d/%0d inst=%h/%h",
                     rdy_a, rdy_b, hold_a, hold_b, ovf_a, ovf_b, oob_a, oob_b, wl_a, wl_b, inst_a, inst_b);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b, hold_a, hold_b} !== 4'b0011 || wl_a !== 9'd0) begin
            errors++;
            $display("FAIL idle_hold: ready=%b/%b hold=%b/%b wl=%0d, required 0/0 1/1 0", rdy_a, rdy_b, hold_a, hold_b, wl_a);
        end
        fetch = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic test_basic();
        start_load();
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b1);
        finish_load("basic");
        check_fetch("basic", 16'd0);
        check_fetch("basic", 16'd1);
    endtask

    task automatic test_random_gaps();
        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(5, 20);
            start_load();
            for (int i = 0; i < n; i++) send_word(16'($urandom), i == n - 1);
            finish_load("random");
            for (int i = 0; i < 8; i++) check_fetch("random", 16'($urandom_range(0, n - 1)));
        end
    endtask

    task automatic test_overflow();
        start_load();
        for (int i = 0; i < 5; i++) send_word(16'hA000 + 16'(i + 1), i == 4);
        finish_load("overflow");
        for (int i = 0; i < 4; i++) check_fetch("overflow", 16'(i));
    endtask

    task automatic test_oob();
        check_fetch("oob", 16'h0100);
        checks++;
        if ({oob_a, oob_b} !== 2'b11) begin
            errors++;
            $display("FAIL oob_set: got %b/%b, required 1/1", oob_a, oob_b);
        end
        check_fetch("oob", 16'd2);
        repeat (3) @(negedge clk);
        checks++;
        if ({oob_a, oob_b} !== 2'b11) begin
            errors++;
            $display("FAIL oob_sticky: got %b/%b, required 1/1", oob_a, oob_b);
        end
        start_load();
        fetch = 1'b1;
        pc = 16'hFFFF;
        #1;
        checks++;
        if ({oob_a, oob_b} !== 2'b00 || inst_a !== 16'h0 || inst_b !== 16'h0) begin
            errors++;
            $display("FAIL oob_clear_load: oob=%b/%b inst=%h/%h, required 0/0 0000", oob_a, oob_b, inst_a, inst_b);
        end
        @(negedge clk);
        fetch = 1'b0;
        checks++;
        if ({oob_a, oob_b} !== 2'b00) begin
            errors++;
            $display("FAIL oob_ignored_in_load: got %b/%b, required 0/0", oob_a, oob_b);
        end
        for (int i = 0; i < 6; i++) send_word(16'($urandom), i == 5);
        finish_load("oob_reload");
        check_fetch("oob_edge", 16'd4);
        checks++;
        if ({oob_a, oob_b} !== 2'b01) begin
            errors++;
            $display("FAIL oob_edge: got %b/%b, required 0/1", oob_a, oob_b);
        end
    endtask

    task automatic test_restart();
        start_load();
        send_byte(8'hEE, 1'b0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h99; ld_last = 1'b1;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        cur.delete();
        checks++;
        if ({ovf_a, ovf_b, oob_a, oob_b} !== 4'b0000 || wl_a !== 9'd0 || {rdy_a, hold_a} !== 2'b11) begin
            errors++;
            $display("FAIL restart_clear: ovf=%b/%b oob=%b/%b wl=%0d ready=%b hold=%b", ovf_a, ovf_b, oob_a, oob_b, wl_a, rdy_a, hold_a);
        end
        send_word(16'hABCD, 1'b1);
        finish_load("restart");
        check_fetch("restart", 16'd0);
    endtask

    task automatic test_reset_midload();
        logic [15:0] w1;
        w1 = 16'($urandom);
        start_load();
        send_word(w1, 1'b0);
        send_byte(8'h5A, 1'b0);
        rst = 1'b1; ld_valid = 1'b1; ld_byte = 8'hC3; ld_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply_model();
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b, hold_a, hold_b} !== 4'b0011 || wl_a !== 9'd0 || wl_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_midload: ready=%b/%b hold=%b/%b wl=%0d/%0d, required 0/0 1/1 0/0", rdy_a, rdy_b, hold_a, hold_b, wl_a, wl_b);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        start_load();
        send_word(16'h0F0F, 1'b1);
        finish_load("reload");
        for (int i = 0; i < 6; i++) check_fetch("reload", 16'(i));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_random_gaps();
        test_overflow();
        test_oob();
        test_restart();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
